// File: rtl/counter_sequencer.sv
// Command-driven sequencer owning a WIDTH-bit counter with free-run / one-shot modes.
// Latency: accepted command visible one cycle later; first count step PRESCALE edges after START.
// Backpressure: cmd_ready is low only in the one-cycle DONE state and during/just out of reset.
module counter_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             wrap,
    output logic             done,
    output logic [1:0]       state
);

    // Prescaler is at least one bit wide so PRESCALE=1 still elaborates cleanly.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    localparam logic [1:0] OP_START     = 2'b00;
    localparam logic [1:0] OP_STOP      = 2'b01;
    localparam logic [1:0] OP_LOAD      = 2'b10;
    localparam logic [1:0] OP_SET_LIMIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] limit_q,   limit_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic             oneshot_q, oneshot_d;
    logic             wrap_q,    wrap_d;
    logic             done_q,    done_d;
    logic             ready_q,   ready_d;
    logic             running_q, running_d;

    logic cmd_fire;
    logic tick;

    // cmd_ready is a flop, so the handshake never depends combinationally on inputs.
    assign cmd_fire = cmd_valid && ready_q;
    assign tick     = (state_q == ST_RUN) && (presc_q == PRE_LAST);

    // Next-state: DONE drains first, then an accepted command, then the tick; a command
    // always pre-empts a coincident tick and restarts the prescaler.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        presc_d   = '0;
        oneshot_d = oneshot_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;

        if (state_q == ST_DONE) begin
            // One-cycle completion state; count was already zeroed on the final tick.
            state_d = ST_IDLE;
        end else if (cmd_fire) begin
            case (cmd_op)
                OP_START: begin
                    // From IDLE/PAUSE this (re)starts with the retained count; in RUN it
                    // only swaps the mode and realigns the prescaler.
                    state_d   = ST_RUN;
                    oneshot_d = cmd_data[0];
                end
                OP_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end else if (state_q == ST_PAUSE) begin
                        // Second stop in a row clears the counter.
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
                OP_LOAD: begin
                    count_d = (cmd_data > limit_q) ? limit_q : cmd_data;
                end
                OP_SET_LIMIT: begin
                    limit_d = cmd_data;
                    if (count_q > cmd_data) begin
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                if (count_q == limit_q) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                    if (oneshot_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PRE_ONE;
            end
        end

        ready_d   = (state_d != ST_DONE);
        running_d = (state_d == ST_RUN);
    end

    // State register with synchronous reset; reset also drops any command presented with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            limit_q   <= '1;
            presc_q   <= '0;
            oneshot_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            presc_q   <= presc_d;
            oneshot_q <= oneshot_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            running_q <= running_d;
        end
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign running   = running_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: directed steps push hand-computed snapshots, a negedge monitor compares.
// Two instances cover PRESCALE=1 (A) and PRESCALE=2 (B).
// Each step drives one instance and expects one snapshot after the following edge.
module tb_counter_sequencer;

    localparam logic [1:0] S_I = 2'b00, S_R = 2'b01, S_P = 2'b10, S_D = 2'b11;
    localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_LOAD = 2'b10, OP_LIM = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, va = 1'b0, rdy_a, run_a, wrap_a, done_a;
    logic [1:0] opa = 2'b00, st_a;
    logic [3:0] da = 4'd0, cnt_a;
    logic       rst_b = 1'b1, vb = 1'b0, rdy_b, run_b, wrap_b, done_b;
    logic [1:0] opb = 2'b00, st_b;
    logic [3:0] db = 4'd0, cnt_b;

    counter_sequencer #(.WIDTH(4), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst_a), .cmd_valid(va), .cmd_ready(rdy_a), .cmd_op(opa),
        .cmd_data(da), .count(cnt_a), .running(run_a), .wrap(wrap_a), .done(done_a),
        .state(st_a)
    );

    counter_sequencer #(.WIDTH(4), .PRESCALE(2)) u_b (
        .clk(clk), .rst(rst_b), .cmd_valid(vb), .cmd_ready(rdy_b), .cmd_op(opb),
        .cmd_data(db), .count(cnt_b), .running(run_b), .wrap(wrap_b), .done(done_b),
        .state(st_b)
    );

    // Snapshot layout: {ready, running, state[1:0], wrap, done, count[3:0]}
    logic [9:0] qa[$], qb[$];
    string      ta[$], tb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [9:0] mk(input logic [3:0] c, input logic [1:0] s,
                                      input logic w, input logic dn, input logic rdy);
        return {rdy, (s == S_R), s, w, dn, c};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d st=%0d wrap=%b done=%b run=%b rdy=%b, expected cnt=%0d st=%0d wrap=%b done=%b run=%b rdy=%b",
                     tag, got[3:0], got[7:6], got[5], got[4], got[8], got[9],
                     exp[3:0], exp[7:6], exp[5], exp[4], exp[8], exp[9]);
        end
    endtask

    // Monitor: one snapshot per instance per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            check(ta.pop_front(), {rdy_a, run_a, st_a, wrap_a, done_a, cnt_a}, qa.pop_front());
        end
        if (qb.size() > 0) begin
            check(tb.pop_front(), {rdy_b, run_b, st_b, wrap_b, done_b, cnt_b}, qb.pop_front());
        end
    end

    task automatic step(input int sel, input logic r, input logic v, input logic [1:0] op,
                        input logic [3:0] d, input logic [9:0] e, input string tag);
        if (sel == 0) begin
            rst_a = r; va = v; opa = op; da = d; vb = 1'b0;
        end else begin
            rst_b = r; vb = v; opb = op; db = d; va = 1'b0;
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            qa.push_back(e); ta.push_back(tag);
        end else begin
            qb.push_back(e); tb.push_back(tag);
        end
    endtask

    task automatic idle(input int sel, input logic [9:0] e, input string tag);
        step(sel, 1'b0, 1'b0, 2'b00, 4'd0, e, tag);
    endtask

    task automatic cmd(input int sel, input logic [1:0] op, input logic [3:0] d,
                       input logic [9:0] e, input string tag);
        step(sel, 1'b0, 1'b1, op, d, e, tag);
    endtask

    task automatic summary;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected end within 2000 cycles");
        summary();
        $finish;
    end

    initial begin
        // ---------------- Instance A, PRESCALE=1 ----------------
        step(0, 1'b1, 1'b0, 2'b00, 4'd0, mk(0, S_I, 0, 0, 0), "a_rst0");
        step(0, 1'b1, 1'b0, 2'b00, 4'd0, mk(0, S_I, 0, 0, 0), "a_rst1");
        idle(0, mk(0, S_I, 0, 0, 1), "a_idle");
        cmd(0, OP_START, 4'd0, mk(0, S_R, 0, 0, 1), "a_start");
        for (int k = 1; k <= 15; k++) idle(0, mk(4'(k), S_R, 0, 0, 1), "a_free");
        idle(0, mk(0, S_R, 1, 0, 1), "a_wrap");
        idle(0, mk(1, S_R, 0, 0, 1), "a_after_wrap1");
        idle(0, mk(2, S_R, 0, 0, 1), "a_after_wrap2");

        // Clear, then pause / resume / double stop
        cmd(0, OP_STOP, 4'd0, mk(2, S_P, 0, 0, 1), "a_stop1");
        cmd(0, OP_STOP, 4'd0, mk(0, S_I, 0, 0, 1), "a_stop2");
        cmd(0, OP_START, 4'd0, mk(0, S_R, 0, 0, 1), "a_start0");
        for (int k = 1; k <= 5; k++) idle(0, mk(4'(k), S_R, 0, 0, 1), "a_up");
        cmd(0, OP_STOP, 4'd0, mk(5, S_P, 0, 0, 1), "a_pause");
        repeat (10) idle(0, mk(5, S_P, 0, 0, 1), "a_hold");
        cmd(0, OP_START, 4'd0, mk(5, S_R, 0, 0, 1), "a_resume");
        idle(0, mk(6, S_R, 0, 0, 1), "a_resume_inc");
        cmd(0, OP_STOP, 4'd0, mk(6, S_P, 0, 0, 1), "a_dstop1");
        cmd(0, OP_STOP, 4'd0, mk(0, S_I, 0, 0, 1), "a_dstop2");
        cmd(0, OP_STOP, 4'd0, mk(0, S_I, 0, 0, 1), "a_stop_idle");

        // LOAD / SET_LIMIT edge cases
        cmd(0, OP_LIM,  4'd9,  mk(0, S_I, 0, 0, 1), "a_lim9");
        cmd(0, OP_LOAD, 4'd12, mk(9, S_I, 0, 0, 1), "a_load_clamp");
        cmd(0, OP_LOAD, 4'd7,  mk(7, S_I, 0, 0, 1), "a_load7");
        cmd(0, OP_LIM,  4'd4,  mk(0, S_I, 0, 0, 1), "a_lim4_clear");
        cmd(0, OP_START, 4'd0, mk(0, S_R, 0, 0, 1), "a_start_l4");
        idle(0, mk(1, S_R, 0, 0, 1), "a_l4_1");
        cmd(0, OP_LOAD, 4'd2,  mk(2, S_R, 0, 0, 1), "a_load_tick");
        idle(0, mk(3, S_R, 0, 0, 1), "a_l4_3");
        idle(0, mk(4, S_R, 0, 0, 1), "a_l4_4");
        cmd(0, OP_LOAD, 4'd2,  mk(2, S_R, 0, 0, 1), "a_load_wrap_edge");
        idle(0, mk(3, S_R, 0, 0, 1), "a_l4_3b");
        idle(0, mk(4, S_R, 0, 0, 1), "a_l4_4b");
        idle(0, mk(0, S_R, 1, 0, 1), "a_l4_wrap");
        idle(0, mk(1, S_R, 0, 0, 1), "a_l4_after");

        // Limit 0: every tick wraps
        cmd(0, OP_LIM, 4'd0, mk(0, S_R, 0, 0, 1), "a_lim0");
        idle(0, mk(0, S_R, 1, 0, 1), "a_lim0_wrap1");
        idle(0, mk(0, S_R, 1, 0, 1), "a_lim0_wrap2");

        // Reset mid-run at count 8 with a command pending
        cmd(0, OP_LIM, 4'd10, mk(0, S_R, 0, 0, 1), "a_lim10");
        for (int k = 1; k <= 8; k++) idle(0, mk(4'(k), S_R, 0, 0, 1), "a_to8");
        step(0, 1'b1, 1'b1, OP_LOAD, 4'd3, mk(0, S_I, 0, 0, 0), "a_rst_mid");
        idle(0, mk(0, S_I, 0, 0, 1), "a_post_rst");
        cmd(0, OP_LOAD, 4'd12, mk(12, S_I, 0, 0, 1), "a_limit_reset");

        // ---------------- Instance B, PRESCALE=2 ----------------
        idle(1, mk(0, S_I, 0, 0, 1), "b_rel");
        cmd(1, OP_LIM, 4'd3, mk(0, S_I, 0, 0, 1), "b_lim3");
        cmd(1, OP_START, 4'd1, mk(0, S_R, 0, 0, 1), "b_start_os");
        idle(1, mk(0, S_R, 0, 0, 1), "b_os0");
        idle(1, mk(1, S_R, 0, 0, 1), "b_os1a");
        idle(1, mk(1, S_R, 0, 0, 1), "b_os1b");
        idle(1, mk(2, S_R, 0, 0, 1), "b_os2a");
        idle(1, mk(2, S_R, 0, 0, 1), "b_os2b");
        idle(1, mk(3, S_R, 0, 0, 1), "b_os3a");
        idle(1, mk(3, S_R, 0, 0, 1), "b_os3b");
        idle(1, mk(0, S_D, 1, 1, 0), "b_done");
        cmd(1, OP_LOAD, 4'd2, mk(0, S_I, 0, 0, 1), "b_done_drop");
        idle(1, mk(0, S_I, 0, 0, 1), "b_idle");

        // Command on a tick edge discards the tick and restarts the prescaler
        cmd(1, OP_LIM, 4'd15, mk(0, S_I, 0, 0, 1), "b_lim15");
        cmd(1, OP_START, 4'd0, mk(0, S_R, 0, 0, 1), "b_start_fr");
        idle(1, mk(0, S_R, 0, 0, 1), "b_pre1");
        cmd(1, OP_LOAD, 4'd5, mk(5, S_R, 0, 0, 1), "b_load_tick");
        idle(1, mk(5, S_R, 0, 0, 1), "b_pre_restart");
        idle(1, mk(6, S_R, 0, 0, 1), "b_tick6");
        idle(1, mk(6, S_R, 0, 0, 1), "b_pre6");
        cmd(1, OP_START, 4'd0, mk(6, S_R, 0, 0, 1), "b_start_in_run");
        idle(1, mk(6, S_R, 0, 0, 1), "b_pre_realign");
        idle(1, mk(7, S_R, 0, 0, 1), "b_tick7");
        cmd(1, OP_STOP, 4'd0, mk(7, S_P, 0, 0, 1), "b_stop1");
        cmd(1, OP_STOP, 4'd0, mk(0, S_I, 0, 0, 1), "b_stop2");
        idle(1, mk(0, S_I, 0, 0, 1), "b_end");

        // Drain pending expectations, bounded
        for (int i = 0; i < 4 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
        #1;
        if ((qa.size() + qb.size()) > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending snapshots, expected 0", qa.size() + qb.size());
        end
        summary();
        $finish;
    end

endmodule
